// File: rtl/uart_tx_arbiter_if.sv
// Byte-stream bundle between num_ports AXI-stream requesters and the single uart_tx input.
// The slave modport is the arbiter's view; the master modport is the requesters'/uart_tx view.
interface uart_tx_arbiter_if #(
   parameter int unsigned num_ports = 4
);
   logic [num_ports-1:0]   s_tvalid;
   logic [num_ports-1:0]   s_tready;
   logic [8*num_ports-1:0] s_tdata;
   logic [num_ports-1:0]   s_tlast;
   logic                   m_tvalid;
   logic                   m_tready;
   logic [7:0]             m_tdata;

   modport master (
      output s_tvalid, s_tdata, s_tlast, m_tready,
      input  s_tready, m_tvalid, m_tdata
   );

   modport slave (
      input  s_tvalid, s_tdata, s_tlast, m_tready,
      output s_tready, m_tvalid, m_tdata
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter sharing one uart_tx byte input, with optional burst cap.
// Define UART_TX_ARBITER_TIMEOUT_EN to revoke a grant whose owner stalls for timeout_cycles.
module uart_tx_arbiter #(
   parameter int unsigned num_ports      = 4,
   parameter int unsigned max_burst      = 16,
   parameter int unsigned timeout_cycles = 1000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   uart_tx_arbiter_if.slave     bus,
   output logic [num_ports-1:0] grant,
   output logic                 busy,
   output logic                 timeout
);

   localparam int unsigned PTR_W = $clog2(num_ports);
   localparam int unsigned CNT_W = (max_burst == 0) ? 1 : $clog2(max_burst + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(max_burst - 1);

   if (num_ports < 2 || num_ports > 8) begin : g_bad_ports
      $error("uart_tx_arbiter: num_ports must be 2..8");
   end
   if (timeout_cycles == 0) begin : g_bad_timeout
      $error("uart_tx_arbiter: timeout_cycles must be nonzero");
   end

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t               state, state_nxt;
   logic [PTR_W-1:0]     ptr, ptr_nxt;
   logic [PTR_W-1:0]     owner, owner_nxt;
   logic [PTR_W-1:0]     sel, idx;
   logic [num_ports-1:0] grant_nxt;
   logic [CNT_W-1:0]     cnt, cnt_nxt;
   logic                 xfer, tlast_g, burst_hit, rel;

   // Owner's byte path straight through to uart_tx; nothing passes while idle
   always_comb begin
      bus.m_tdata  = '0;
      bus.m_tvalid = 1'b0;
      bus.s_tready = '0;
      for (int i = 0; i < int'(num_ports); i++) begin
         if (grant[i]) bus.m_tdata = bus.s_tdata[8*i +: 8];
      end
      if (state == LOCKED) begin
         bus.m_tvalid = |(bus.s_tvalid & grant);
         bus.s_tready = grant & {num_ports{bus.m_tready}};
      end
   end

   assign xfer      = bus.m_tvalid & bus.m_tready;
   assign tlast_g   = |(bus.s_tlast & grant);
   assign burst_hit = (max_burst != 0) && (cnt == CNT_LAST);

   // First requester after the pointer, with wrap-around; smallest offset wins
   always_comb begin
      sel = ptr;
      idx = ptr;
      for (int k = int'(num_ports); k >= 1; k--) begin
         idx = PTR_W'((int'(ptr) + k) % int'(num_ports));
         if (bus.s_tvalid[idx]) sel = idx;
      end
   end

`ifdef UART_TX_ARBITER_TIMEOUT_EN
   localparam int unsigned STALL_W = $clog2(timeout_cycles + 1);
   localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(timeout_cycles - 1);

   logic [STALL_W-1:0] stall_cnt, stall_nxt;
   logic               timeout_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
         timeout   <= 1'b0;
      end else begin
         stall_cnt <= stall_nxt;
         timeout   <= timeout_nxt;
      end
   end
`else
   assign timeout = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      owner_nxt = owner;
      grant_nxt = grant;
      cnt_nxt   = cnt;
      rel       = 1'b0;
`ifdef UART_TX_ARBITER_TIMEOUT_EN
      stall_nxt   = stall_cnt;
      timeout_nxt = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (|bus.s_tvalid) begin
               state_nxt = LOCKED;
               owner_nxt = sel;
               grant_nxt = num_ports'(1) << sel;
            end
         end
         LOCKED: begin
            if (xfer) begin
               if (tlast_g || burst_hit) rel = 1'b1;
               else if (max_burst != 0) cnt_nxt = cnt + 1'b1;
            end
`ifdef UART_TX_ARBITER_TIMEOUT_EN
            // Owner with no byte on offer: count toward revocation
            if (!(|(bus.s_tvalid & grant))) begin
               if (stall_cnt == STALL_LAST) begin
                  rel         = 1'b1;
                  timeout_nxt = 1'b1;
               end else begin
                  stall_nxt = stall_cnt + 1'b1;
               end
            end else begin
               stall_nxt = '0;
            end
`endif
         end
         default: state_nxt = IDLE;
      endcase
      if (rel) begin
         state_nxt = IDLE;
         ptr_nxt   = owner;
         grant_nxt = '0;
         cnt_nxt   = '0;
`ifdef UART_TX_ARBITER_TIMEOUT_EN
         stall_nxt = '0;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         ptr   <= PTR_W'(num_ports - 1);
         owner <= '0;
         grant <= '0;
         cnt   <= '0;
         busy  <= 1'b0;
      end else begin
         state <= state_nxt;
         ptr   <= ptr_nxt;
         owner <= owner_nxt;
         grant <= grant_nxt;
         cnt   <= cnt_nxt;
         busy  <= (state_nxt == LOCKED);
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed vector table, burst/stall/reset sequences, and
// randomized packet traffic checked against a packet-queue round-robin model.
module tb_uart_tx_arbiter;

   localparam int unsigned NP = 4;
   localparam int unsigned MB = 4;
   localparam int unsigned TO = 8;

   typedef struct packed {
      logic       last;
      logic [7:0] data;
   } beat_t;

   typedef struct {
      int         port;
      logic [7:0] data;
   } exp_t;

   typedef struct {
      bit          rst;
      logic [3:0]  vld;
      logic [3:0]  lst;
      logic [31:0] dat;
      logic        mrdy;
      logic [3:0]  e_grant;
      logic        e_mv;
      logic [7:0]  e_md;
      logic [3:0]  e_srdy;
      logic        e_busy;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [NP-1:0] grant;
   logic          busy;
   logic          timeout;

   int checks = 0;
   int errors = 0;

   beat_t q [NP][$];
   exp_t  expq[$];
   int    hold [NP];
   vec_t  vt[$];

   uart_tx_arbiter_if #(.num_ports(NP)) bus ();

   uart_tx_arbiter #(
      .num_ports     (NP),
      .max_burst     (MB),
      .timeout_cycles(TO)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .bus    (bus),
      .grant  (grant),
      .busy   (busy),
      .timeout(timeout)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic set_port(input int i, input logic v, input logic [7:0] d, input logic l);
      bus.s_tvalid[i]        = v;
      bus.s_tdata[8*i +: 8]  = d;
      bus.s_tlast[i]         = l;
   endtask

   task automatic clear_inputs();
      bus.s_tvalid = '0;
      bus.s_tlast  = '0;
      bus.s_tdata  = '0;
      bus.m_tready = 1'b0;
   endtask

   task automatic do_reset();
      rst_n        = 1'b0;
      bus.s_tvalid = '1;
      bus.s_tlast  = '0;
      bus.m_tready = 1'b1;
      #2;
      check("rst_grant",   32'(grant), 32'h0);
      check("rst_busy",    32'(busy), 32'h0);
      check("rst_timeout", 32'(timeout), 32'h0);
      check("rst_mtvalid", 32'(bus.m_tvalid), 32'h0);
      check("rst_stready", 32'(bus.s_tready), 32'h0);
      clear_inputs();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Reference: packets drain in round-robin order, each grant ends on tlast or MB bytes
   task automatic build_expected(input int start_ptr);
      beat_t mq [NP][$];
      int    ptr, p, n;
      bit    more;
      beat_t b;
      expq.delete();
      for (int i = 0; i < NP; i++) mq[i] = q[i];
      ptr = start_ptr;
      more = 1'b1;
      while (more) begin
         p = -1;
         for (int k = NP; k >= 1; k--) begin
            if (mq[(ptr + k) % NP].size() > 0) p = (ptr + k) % NP;
         end
         if (p < 0) begin
            more = 1'b0;
         end else begin
            n = 0;
            do begin
               b = mq[p].pop_front();
               expq.push_back('{port: p, data: b.data});
               n++;
            end while (!b.last && n < MB && mq[p].size() > 0);
            ptr = p;
         end
      end
   endtask

   task automatic gen_random();
      int npk, len;
      for (int i = 0; i < NP; i++) begin
         q[i].delete();
         npk = $urandom_range(1, 3);
         for (int k = 0; k < npk; k++) begin
            len = $urandom_range(1, 6);
            for (int b = 0; b < len; b++)
               q[i].push_back('{last: (b == len - 1), data: 8'($urandom)});
         end
      end
   endtask

   // Requesters present their queued bytes; the owner may pause mid-packet when rnd is set
   task automatic run_traffic(input string tag, input int budget, input bit rnd);
      int            cyc;
      int            p;
      logic [NP-1:0] prev_g;
      exp_t          e;
      cyc    = 0;
      prev_g = grant;
      for (int i = 0; i < NP; i++) hold[i] = 0;
      while (expq.size() > 0 && cyc < budget) begin
         @(negedge clk);
         cyc++;
         bus.m_tready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
         for (int i = 0; i < NP; i++) begin
            if (hold[i] > 0) begin
               hold[i]--;
               set_port(i, 1'b0, 8'h00, 1'b0);
            end else if (q[i].size() > 0) begin
               set_port(i, 1'b1, q[i][0].data, q[i][0].last);
            end else begin
               set_port(i, 1'b0, 8'h00, 1'b0);
            end
         end
         #4;
         check({tag, "_stready_owner"}, 32'(bus.s_tready & ~grant), 32'h0);
         if (grant != prev_g && grant != '0)
            check({tag, "_bubble"}, 32'(prev_g), 32'h0);
         prev_g = grant;
         p = -1;
         if (bus.m_tvalid && bus.m_tready) begin
            for (int i = 0; i < NP; i++) if (bus.s_tready[i]) p = i;
            e = expq.pop_front();
            check({tag, "_port"}, 32'(p), 32'(e.port));
            check({tag, "_data"}, 32'(bus.m_tdata), 32'(e.data));
            if (p >= 0 && q[p].size() > 0) void'(q[p].pop_front());
         end
         @(posedge clk);
         #1;
         if (rnd && p >= 0 && grant[p] && q[p].size() > 0 && $urandom_range(0, 2) == 0)
            hold[p] = $urandom_range(1, 3);
      end
      check({tag, "_drain"}, 32'(expq.size()), 32'h0);
      @(negedge clk);
      clear_inputs();
   endtask

   initial begin
      clear_inputs();

      // Single packet on port 2
      vt.push_back('{1, 4'b0100, 4'b0000, 32'h005A0000, 1, 4'b0000, 0, 8'h00, 4'b0000, 0});
      vt.push_back('{0, 4'b0100, 4'b0000, 32'h005A0000, 1, 4'b0100, 1, 8'h5A, 4'b0100, 1});
      vt.push_back('{0, 4'b0100, 4'b0100, 32'h00C30000, 1, 4'b0100, 1, 8'hC3, 4'b0100, 1});
      vt.push_back('{0, 4'b0000, 4'b0000, 32'h00000000, 1, 4'b0000, 0, 8'h00, 4'b0000, 0});
      // Round-robin with 1-byte packets on all ports, one backpressure cycle
      vt.push_back('{1, 4'b1111, 4'b1111, 32'h13121110, 1, 4'b0000, 0, 8'h00, 4'b0000, 0});
      vt.push_back('{0, 4'b1111, 4'b1111, 32'h13121110, 1, 4'b0001, 1, 8'h10, 4'b0001, 1});
      vt.push_back('{0, 4'b1111, 4'b1111, 32'h13121110, 1, 4'b0000, 0, 8'h00, 4'b0000, 0});
      vt.push_back('{0, 4'b1111, 4'b1111, 32'h13121110, 0, 4'b0010, 1, 8'h11, 4'b0000, 1});
      vt.push_back('{0, 4'b1111, 4'b1111, 32'h13121110, 1, 4'b0010, 1, 8'h11, 4'b0010, 1});
      vt.push_back('{0, 4'b1111, 4'b1111, 32'h13121110, 1, 4'b0000, 0, 8'h00, 4'b0000, 0});
      vt.push_back('{0, 4'b1111, 4'b1111, 32'h13121110, 1, 4'b0100, 1, 8'h12, 4'b0100, 1});
      vt.push_back('{0, 4'b1111, 4'b1111, 32'h13121110, 1, 4'b0000, 0, 8'h00, 4'b0000, 0});
      vt.push_back('{0, 4'b1111, 4'b1111, 32'h13121110, 1, 4'b1000, 1, 8'h13, 4'b1000, 1});
      vt.push_back('{0, 4'b1111, 4'b1111, 32'h13121110, 1, 4'b0000, 0, 8'h00, 4'b0000, 0});
      vt.push_back('{0, 4'b1111, 4'b1111, 32'h13121110, 1, 4'b0001, 1, 8'h10, 4'b0001, 1});
      // Packet lock: port 1 requests during port 0's 3-byte packet
      vt.push_back('{1, 4'b0001, 4'b0000, 32'h000000A0, 1, 4'b0000, 0, 8'h00, 4'b0000, 0});
      vt.push_back('{0, 4'b0011, 4'b0010, 32'h0000B1A0, 1, 4'b0001, 1, 8'hA0, 4'b0001, 1});
      vt.push_back('{0, 4'b0011, 4'b0010, 32'h0000B1A1, 1, 4'b0001, 1, 8'hA1, 4'b0001, 1});
      vt.push_back('{0, 4'b0011, 4'b0011, 32'h0000B1A2, 1, 4'b0001, 1, 8'hA2, 4'b0001, 1});
      vt.push_back('{0, 4'b0010, 4'b0010, 32'h0000B100, 1, 4'b0000, 0, 8'h00, 4'b0000, 0});
      vt.push_back('{0, 4'b0010, 4'b0010, 32'h0000B100, 1, 4'b0010, 1, 8'hB1, 4'b0010, 1});
      vt.push_back('{0, 4'b0000, 4'b0000, 32'h00000000, 1, 4'b0000, 0, 8'h00, 4'b0000, 0});

      foreach (vt[n]) begin
         if (vt[n].rst) do_reset();
         @(negedge clk);
         bus.s_tvalid = vt[n].vld;
         bus.s_tlast  = vt[n].lst;
         bus.s_tdata  = vt[n].dat;
         bus.m_tready = vt[n].mrdy;
         #4;
         check($sformatf("v%0d_grant", n),  32'(grant), 32'(vt[n].e_grant));
         check($sformatf("v%0d_mtvalid", n), 32'(bus.m_tvalid), 32'(vt[n].e_mv));
         if (vt[n].e_mv)
            check($sformatf("v%0d_mtdata", n), 32'(bus.m_tdata), 32'(vt[n].e_md));
         check($sformatf("v%0d_stready", n), 32'(bus.s_tready), 32'(vt[n].e_srdy));
         check($sformatf("v%0d_busy", n),   32'(busy), 32'(vt[n].e_busy));
      end

      // Burst cap: pointer sits at 1, so port 3 wins, is cut after MB bytes, port 0 interleaves
      for (int i = 0; i < NP; i++) q[i].delete();
      for (int b = 0; b < 6; b++) q[3].push_back('{last: (b == 5), data: 8'(8'hB0 + b)});
      q[0].push_back('{last: 1'b1, data: 8'hC0});
      expq.delete();
      for (int b = 0; b < 4; b++) expq.push_back('{port: 3, data: 8'(8'hB0 + b)});
      expq.push_back('{port: 0, data: 8'hC0});
      expq.push_back('{port: 3, data: 8'hB4});
      expq.push_back('{port: 3, data: 8'hB5});
      run_traffic("burst", 100, 1'b0);

      // Randomized traffic with backpressure and owner pauses
      for (int r = 0; r < 3; r++) begin
         do_reset();
         gen_random();
         build_expected(NP - 1);
         run_traffic($sformatf("rand%0d", r), 3000, 1'b1);
      end

      // Owner stalls mid-packet while port 2 waits
      do_reset();
      @(negedge clk);
      set_port(1, 1'b1, 8'hD0, 1'b0);
      bus.m_tready = 1'b1;
      #4;
      check("stall_idle_grant", 32'(grant), 32'h0);
      @(negedge clk);
      #4;
      check("stall_grant", 32'(grant), 32'b0010);
      check("stall_first", 32'(bus.m_tdata), 32'hD0);
      @(negedge clk);
      set_port(1, 1'b0, 8'h00, 1'b0);
      set_port(2, 1'b1, 8'hE0, 1'b1);
`ifdef UART_TX_ARBITER_TIMEOUT_EN
      for (int s = 1; s <= int'(TO); s++) begin
         @(posedge clk);
         #1;
         if (s < int'(TO)) begin
            check($sformatf("to_hold%0d_grant", s), 32'(grant), 32'b0010);
            check($sformatf("to_hold%0d_pulse", s), 32'(timeout), 32'h0);
            check($sformatf("to_hold%0d_stready", s), 32'(bus.s_tready), 32'b0010);
         end else begin
            check("to_pulse", 32'(timeout), 32'h1);
            check("to_grant_clear", 32'(grant), 32'h0);
            check("to_busy_clear", 32'(busy), 32'h0);
         end
      end
      @(posedge clk);
      #1;
      check("to_pulse_end", 32'(timeout), 32'h0);
      check("to_next_grant", 32'(grant), 32'b0100);
      @(negedge clk);
      #4;
      check("to_next_data", 32'(bus.m_tdata), 32'hE0);
      check("to_next_valid", 32'(bus.m_tvalid), 32'h1);
`else
      for (int s = 1; s <= 12; s++) begin
         @(posedge clk);
         #1;
         check($sformatf("hold%0d_grant", s), 32'(grant), 32'b0010);
         check($sformatf("hold%0d_timeout", s), 32'(timeout), 32'h0);
      end
      @(negedge clk);
      set_port(1, 1'b1, 8'hD1, 1'b1);
      #4;
      check("hold_resume_data", 32'(bus.m_tdata), 32'hD1);
      check("hold_resume_stready", 32'(bus.s_tready), 32'b0010);
      @(negedge clk);
      set_port(1, 1'b0, 8'h00, 1'b0);
      #4;
      check("hold_release", 32'(grant), 32'h0);
      @(negedge clk);
      #4;
      check("hold_next_grant", 32'(grant), 32'b0100);
      check("hold_next_data", 32'(bus.m_tdata), 32'hE0);
`endif
      @(negedge clk);
      clear_inputs();

      // Reset mid-packet clears combinational outputs without a clock edge
      do_reset();
      @(negedge clk);
      set_port(0, 1'b1, 8'hF0, 1'b0);
      bus.m_tready = 1'b1;
      @(negedge clk);
      #4;
      check("midrst_pre_grant", 32'(grant), 32'b0001);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_grant",   32'(grant), 32'h0);
      check("midrst_mtvalid", 32'(bus.m_tvalid), 32'h0);
      check("midrst_stready", 32'(bus.s_tready), 32'h0);
      check("midrst_busy",    32'(busy), 32'h0);
      clear_inputs();
      @(negedge clk);
      rst_n = 1'b1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one uart_tx byte-stream input among num_ports AXI-stream requesters.
- Grants one requester at a time and holds the grant for a whole packet, delimited by tlast.
- Round-robin selection with an optional burst cap for fairness.
- Sits directly upstream of uart_tx: the m_* ports connect to uart_tx tvalid, tready and tdata.

Parameters:
- num_ports, 4, number of requesters (2..8).
- max_burst, 16, maximum bytes per grant before forced release (0 = unlimited, release only on tlast).
- timeout_cycles, 1000, idle-stall limit; used only with the optional feature.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- s_tvalid  input  num_ports  per-requester byte valid.
- s_tready  output  num_ports  per-requester byte accept.
- s_tdata  input  8*num_ports  per-requester byte; requester i uses bits [8i+7:8i].
- s_tlast  input  num_ports  last byte of the requester's packet.
- m_tvalid  output  1  byte valid to uart_tx.
- m_tready  input  1  uart_tx accept.
- m_tdata  output  8  byte to uart_tx.
- grant  output  num_ports  one-hot current owner (all zero when idle).
- busy  output  1  high while any grant is held.
- timeout  output  1  one-cycle pulse when a stalled grant is revoked (tied 0 without the optional feature).

Behaviour:
- Reset (rst_n low, asynchronous):
  - State IDLE; grant = 0, busy = 0, timeout = 0.
  - Round-robin pointer = num_ports-1, so port 0 has first priority.
  - Burst counter = 0.
  - Through the combinational paths, m_tvalid = 0 and s_tready = 0 while reset is held.
- State IDLE:
  - m_tvalid = 0, all s_tready = 0.
  - If any s_tvalid is high, select the first asserted port searching upward from pointer+1 with wrap-around.
  - Register that port into grant and go to LOCKED on the next edge.
  - Arbitration latency is exactly 1 cycle: request seen at edge N, grant visible after edge N, first byte transfer possible at edge N+1.
- State LOCKED (owner g):
  - m_tvalid = s_tvalid[g], m_tdata = s_tdata[g], s_tready[g] = m_tready, combinationally.
  - All other s_tready = 0.
  - m_tdata is don't-care when m_tvalid = 0.
  - A transfer occurs when m_tvalid and m_tready are both high; each transfer increments the burst counter.
- Release from LOCKED to IDLE, on the edge of a transfer where either:
  - s_tlast[g] = 1, or
  - max_burst != 0 and the counter reaches max_burst.
- On release:
  - pointer <- g, grant <- 0, counter <- 0.
  - The next arbitration starts in IDLE, giving a mandatory 1-cycle bubble between grants.
- Burst-cap release mid-packet:
  - The remaining bytes of g's packet compete in a later arbitration.
  - Ports lower in round-robin order may interleave.
  - This is intended; framing is owned by the requester.
- Requester deasserts s_tvalid mid-packet: grant is held; m_tvalid follows low; no bubble is inserted by the arbiter.
- Simultaneous requests: strict round-robin from pointer+1. With all ports requesting continuously with 1-byte packets, grants cycle 0,1,2,3,0...
- Requests arriving while LOCKED are ignored until IDLE. No speculative arbitration.
- busy = (state == LOCKED).
- Backpressure: m_tready low stalls the transfer; s_tdata[g] and s_tvalid[g] must stay stable per AXI-stream rules; the arbiter adds no state change.
- Reset mid-packet: everything returns to reset values immediately; the partially sent packet is abandoned.
- Counter width is $clog2(max_burst+1), minimum 1. No wrap is possible because the cap forces release first.

Optional Feature:
- Macro: UART_TX_ARBITER_TIMEOUT_EN.
- Defined:
  - A stall counter runs in LOCKED while s_tvalid[g] = 0.
  - It clears on any cycle with s_tvalid[g] = 1, and on release.
  - When it reaches timeout_cycles, force release exactly as a tlast release (pointer <- g) and pulse timeout for 1 cycle.
  - A transfer does not occur on that edge.
- Not defined: no stall counter; timeout is constant 0; a stalled owner holds the grant indefinitely.

Test Plan:
- Single packet:
  - Stimulus: port 2 sends 0x5A,0xC3 (tlast on 0xC3) with m_tready = 1.
  - Response: grant = 4'b0100 one cycle after s_tvalid; m_tdata 0x5A then 0xC3 on consecutive edges; grant = 0 and busy = 0 after the last transfer.
- Round-robin:
  - Stimulus: all 4 ports hold 1-byte packets (port i data = 0x10+i) after reset.
  - Response: uart_tx receives 0x10,0x11,0x12,0x13,0x10 in that order, one idle cycle between grants.
- Packet lock:
  - Stimulus: port 0 sends a 3-byte packet; port 1 requests during byte 1.
  - Response: s_tready[1] stays 0 until port 0's tlast transfer; port 1 is granted next.
- Burst cap:
  - Stimulus: max_burst = 4; port 3 sends a 6-byte packet; port 0 is also requesting.
  - Response: 4 bytes from port 3, then port 0's packet, then the remaining 2 bytes of port 3.
- Backpressure through real uart_tx (cycles_per_bit = 434):
  - Stimulus: 2 ports each send 3 random bytes.
  - Response: the serial decoder recovers all 6 bytes in arbitration order; no byte is lost or duplicated.
- Reset and timeout (macro defined, timeout_cycles = 8):
  - Stimulus: port 1 granted, stalls 8 cycles.
  - Response: timeout pulses once, grant clears, port 2 is granted next.
  - Stimulus: assert rst_n = 0 mid-packet.
  - Response: grant = 0 and m_tvalid = 0 immediately, without waiting for a clock edge.
